// File: rtl/debounce_edge_counter.sv
// Debounces a synchronised single-bit level with a consecutive-sample FSM,
// emits one-cycle rise/fall pulses and counts accepted rising edges.
module debounce_edge_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  input  logic                 clr_cnt,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] press_cnt,
  output logic                 overflow,
  output logic [1:0]           dbg_state
);

  localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHK_HIGH    = 2'd1,
    HIGH_STABLE = 2'd2,
    CHK_LOW     = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] stab_inc;
  logic          accept_rise;
  logic          accept_fall;

  // rise/fall carry no handshake: each is a registered single-cycle strobe,
  // high in the cycle after the sample that completed the stable run.
  always_comb begin
    stab_inc    = stab_cnt + SW'(1);
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    if (DEBOUNCE_CYCLES == 1) begin
      accept_rise = (state == LOW_STABLE) && in;
      accept_fall = (state == HIGH_STABLE) && !in;
    end else begin
      accept_rise = (state == CHK_HIGH) && in && (stab_inc == LAST);
      accept_fall = (state == CHK_LOW) && !in && (stab_inc == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOW_STABLE;
      stab_cnt  <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      press_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      rise <= accept_rise;
      fall <= accept_fall;

      case (state)
        LOW_STABLE: begin
          level <= 1'b0;
          if (!in) begin
            stab_cnt <= '0;
          end else if (accept_rise) begin
            state    <= HIGH_STABLE;
            level    <= 1'b1;
            stab_cnt <= '0;
          end else begin
            state    <= CHK_HIGH;
            stab_cnt <= SW'(1);
          end
        end
        CHK_HIGH: begin
          level <= 1'b0;
          if (!in) begin
            state    <= LOW_STABLE;
            stab_cnt <= '0;
          end else if (accept_rise) begin
            state    <= HIGH_STABLE;
            level    <= 1'b1;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_inc;
          end
        end
        HIGH_STABLE: begin
          level <= 1'b1;
          if (in) begin
            stab_cnt <= '0;
          end else if (accept_fall) begin
            state    <= LOW_STABLE;
            level    <= 1'b0;
            stab_cnt <= '0;
          end else begin
            state    <= CHK_LOW;
            stab_cnt <= SW'(1);
          end
        end
        CHK_LOW: begin
          level <= 1'b1;
          if (in) begin
            state    <= HIGH_STABLE;
            stab_cnt <= '0;
          end else if (accept_fall) begin
            state    <= LOW_STABLE;
            level    <= 1'b0;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_inc;
          end
        end
        default: begin
          state    <= LOW_STABLE;
          level    <= 1'b0;
          stab_cnt <= '0;
        end
      endcase

      // Clear wins over the old value but not over a same-cycle press.
      if (clr_cnt) begin
        press_cnt <= accept_rise ? CNT_WIDTH'(1) : '0;
        overflow  <= 1'b0;
      end else if (accept_rise) begin
        press_cnt <= press_cnt + CNT_WIDTH'(1);
        if (press_cnt == '1) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_debounce_edge_counter.sv
// Scoreboard bench: two debouncer instances (4-sample/2-bit count and
// 1-sample/3-bit count) share random stimulus and a run-length reference model.
module tb_debounce_edge_counter;

  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic in = 1'b0;
  logic clr_cnt = 1'b0;

  logic       level4, rise4, fall4, ovf4;
  logic [1:0] cnt4;
  logic [1:0] st4;
  logic       level1, rise1, fall1, ovf1;
  logic [2:0] cnt1;
  logic [1:0] st1;

  debounce_edge_counter #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)) u_dut4 (
    .clk(clk), .reset(reset), .in(in), .clr_cnt(clr_cnt),
    .level(level4), .rise(rise4), .fall(fall4),
    .press_cnt(cnt4), .overflow(ovf4), .dbg_state(st4)
  );

  debounce_edge_counter #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(3)) u_dut1 (
    .clk(clk), .reset(reset), .in(in), .clr_cnt(clr_cnt),
    .level(level1), .rise(rise1), .fall(fall1),
    .press_cnt(cnt1), .overflow(ovf1), .dbg_state(st1)
  );

  // Reference model: a level flips once the trailing run of samples that
  // disagree with it reaches the required length.
  int   n_req[2]   = '{4, 1};
  int   cnt_mod[2] = '{4, 8};
  int   run_m[2];
  logic lvl_m[2];
  int   cnt_m[2];
  logic ovf_m[2];

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic model_step(input logic i, input logic c, input logic r,
                            output logic [W-1:0] e);
    logic [11:0] obs[2];
    for (int k = 0; k < 2; k++) begin
      logic rz;
      logic fz;
      rz = 1'b0;
      fz = 1'b0;
      if (r) begin
        lvl_m[k] = 1'b0;
        run_m[k] = 0;
        cnt_m[k] = 0;
        ovf_m[k] = 1'b0;
      end else begin
        run_m[k] = (i != lvl_m[k]) ? run_m[k] + 1 : 0;
        if (run_m[k] >= n_req[k]) begin
          lvl_m[k] = ~lvl_m[k];
          run_m[k] = 0;
          if (lvl_m[k]) rz = 1'b1;
          else fz = 1'b1;
        end
        if (c) begin
          cnt_m[k] = rz ? 1 : 0;
          ovf_m[k] = 1'b0;
        end else if (rz) begin
          cnt_m[k] = cnt_m[k] + 1;
          if (cnt_m[k] == cnt_mod[k]) begin
            cnt_m[k] = 0;
            ovf_m[k] = 1'b1;
          end
        end
      end
      obs[k] = {lvl_m[k], rz, fz, ovf_m[k], 8'(cnt_m[k])};
    end
    e = {obs[0], obs[1]};
  endtask

  task automatic step(input logic i, input logic c, input logic r);
    logic [W-1:0] e;
    @(negedge clk);
    in      = i;
    clr_cnt = c;
    reset   = r;
    model_step(i, c, r, e);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic i, input int n);
    for (int j = 0; j < n; j++) step(i, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every clock presents an observation; compare it to the head.
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [11:0]  got4;
    logic [11:0]  got1;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      got4 = {level4, rise4, fall4, ovf4, 6'b0, cnt4};
      got1 = {level1, rise1, fall1, ovf1, 5'b0, cnt1};
      total++;
      if (got4 !== e[23:12]) begin
        bad++;
        $display("FAIL dut4 cyc=%0d got lvl/r/f/ovf/cnt=%b required=%b",
                 cyc, got4, e[23:12]);
      end
      total++;
      if (got1 !== e[11:0]) begin
        bad++;
        $display("FAIL dut1 cyc=%0d got lvl/r/f/ovf/cnt=%b required=%b",
                 cyc, got1, e[11:0]);
      end
    end
  end

  initial begin
    // Quiet after reset.
    do_reset();
    hold(1'b0, 10);
    // Clean press and release.
    hold(1'b1, 15);
    hold(1'b0, 10);
    // Glitches shorter than four samples.
    hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 3); hold(1'b0, 6);
    // Five presses to wrap the 2-bit counter, then clear.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    step(1'b0, 1'b1, 1'b0);
    hold(1'b0, 3);
    // Clear coincident with the accepting sample, count at 2.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    hold(1'b1, 3);
    step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 3);
    hold(1'b0, 5);
    // Reset in the middle of a debounce run with the input held high.
    do_reset();
    hold(1'b0, 3);
    hold(1'b1, 2);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 6);
    hold(1'b0, 6);
    // Random bursts with occasional clears and resets.
    for (int b = 0; b < 200; b++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        step(v, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
      end
    end
    hold(1'b0, 6);
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
